// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger link: monitor state encoding and the
// nominal toggle count per burst (also used by the generator side).
package trigger_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int EXPECTED_DEFAULT = 200;

endpackage

// File: rtl/trigger_monitor_if.sv
// Trigger link bundle: incoming toggle bus and clear, plus burst status back.
interface trigger_monitor_if #(
    parameter int CNT_W = 10
);
    logic [2:0]       trig_in;
    logic             clear;
    logic             busy;
    logic             burst_done;
    logic [CNT_W-1:0] pulse_count;
    logic             burst_ok;
    logic             lane_err;
    logic             overflow;

    modport master (
        output trig_in, clear,
        input  busy, burst_done, pulse_count, burst_ok, lane_err, overflow
    );

    modport slave (
        input  trig_in, clear,
        output busy, burst_done, pulse_count, burst_ok, lane_err, overflow
    );
endinterface

// File: rtl/trig_sync.sv
// 3-lane two-flop synchronizer with a history stage; lane 0 defines toggle events.
module trig_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] trig_i,
    output logic [2:0] sync_o,
    output logic       evt_o,
    output logic       lane_diff_o
);
    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic [2:0] hist_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            meta_q <= trig_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign sync_o      = sync_q;
    assign evt_o       = sync_q[0] ^ hist_q[0];
    assign lane_diff_o = (sync_q != {3{sync_q[0]}});
endmodule

// File: rtl/trigger_monitor.sv
// Receive side of the trigger link: counts lane-0 toggles per burst, ends a
// burst after an idle timeout and reports count, pass/fail and lane errors.
module trigger_monitor
    import trigger_pkg::*;
#(
    parameter int CNT_W    = 10,
    parameter int EXPECTED = EXPECTED_DEFAULT,
    parameter int TIMEOUT  = 5_000_000,
    parameter int TO_W     = 23
) (
    input  logic              clk,
    input  logic              reset,
    trigger_monitor_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0]       sync_bus;
    logic             evt;
    logic             lane_diff;

    state_e           state_q;
    logic [TO_W-1:0]  idle_q, idle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       diff_pat_q, diff_pat_d;
    logic             busy_q, done_q, ok_q, lerr_q, ovf_q;
    logic             lerr_d, ovf_d;

    trig_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .trig_i      (bus.trig_in),
        .sync_o      (sync_bus),
        .evt_o       (evt),
        .lane_diff_o (lane_diff)
    );

    // A lane error needs the same lanes out of step on two consecutive
    // cycles, so a one-cycle skew through the synchronizer is tolerated.
    always_comb begin
        diff_pat_d = sync_bus[2:1] ^ {2{sync_bus[0]}};
        lerr_d     = lerr_q | (lane_diff && (diff_pat_d == diff_pat_q));
        idle_d     = idle_q + TO_W'(1);
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idle_q     <= '0;
            cnt_q      <= '0;
            diff_pat_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            lerr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            diff_pat_q <= diff_pat_d;
            done_q     <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (evt) begin
                        state_q <= ACTIVE;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_W'(1);
                        idle_q  <= '0;
                        lerr_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        ok_q    <= 1'b0;
                    end else if (state_q == DONE && bus.clear) begin
                        state_q <= IDLE;
                        ok_q    <= 1'b0;
                    end
                end
                ACTIVE: begin
                    lerr_q <= lerr_d;
                    if (evt) begin
                        cnt_q  <= cnt_d;
                        ovf_q  <= ovf_d;
                        idle_q <= '0;
                    end else if (idle_q == TO_LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ok_q    <= (int'(cnt_q) == EXPECTED) && !lerr_d && !ovf_q;
                    end else begin
                        idle_q <= idle_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.burst_done  = done_q;
    assign bus.pulse_count = cnt_q;
    assign bus.burst_ok    = ok_q;
    assign bus.lane_err    = lerr_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_trigger_monitor.sv
// Scoreboard bench for trigger_monitor: a 10-bit and a 4-bit instance with a
// short idle timeout; burst results are queued at stimulus time.
module tb_trigger_monitor;
    localparam int TMO       = 16;
    localparam int DONE_DLY  = 3 + TMO;

    typedef struct {
        int cnt;
        bit ok;
        bit lerr;
        bit ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   last_drive = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];

    trigger_monitor_if #(.CNT_W(10)) bus_a ();
    trigger_monitor_if #(.CNT_W(4))  bus_b ();

    trigger_monitor #(.CNT_W(10), .EXPECTED(200), .TIMEOUT(TMO), .TO_W(5)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    trigger_monitor #(.CNT_W(4), .EXPECTED(200), .TIMEOUT(TMO), .TO_W(5)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] get_trig(input bit sel);
        return sel ? bus_b.trig_in : bus_a.trig_in;
    endfunction

    task automatic set_trig(input bit sel, input logic [2:0] v);
        if (sel) bus_b.trig_in = v;
        else     bus_a.trig_in = v;
    endtask

    // mode 1: lane 2 inverted for 5 clk after toggle 100; mode 2: lane 1 one clk late on toggle 100
    task automatic burst(input bit sel, input int n, input int mode);
        logic [2:0] cur;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            cur = get_trig(sel);
            if (mode == 2 && i == 100) set_trig(sel, cur ^ 3'b101);
            else                       set_trig(sel, ~cur);
            cur = ~cur;
            last_drive = cyc;
            for (int c = 1; c < 8; c++) begin
                @(posedge clk); #1;
                if (mode == 2 && i == 100 && c == 1) set_trig(sel, cur);
                if (mode == 1 && i == 100 && (c == 1 || c == 6)) set_trig(sel, get_trig(sel) ^ 3'b100);
            end
        end
    endtask

    task automatic wait_results();
        int budget = 200;
        while ((qa.size() != 0 || qb.size() != 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        chk("result_timeout", qa.size() + qb.size(), 0);
    endtask

    task automatic push_a(input int cnt, input bit ok, input bit lerr, input bit ovf);
        exp_t e;
        e.cnt = cnt; e.ok = ok; e.lerr = lerr; e.ovf = ovf;
        qa.push_back(e);
    endtask

    // Scoreboard side: every burst_done pulse consumes one expected result.
    always begin
        exp_t e;
        @(posedge clk); #1;
        if (!reset && bus_a.burst_done) begin
            if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_count", bus_a.pulse_count, e.cnt);
                chk("a_ok", bus_a.burst_ok, e.ok);
                chk("a_lane_err", bus_a.lane_err, e.lerr);
                chk("a_overflow", bus_a.overflow, e.ovf);
                chk("a_busy_at_done", bus_a.busy, 0);
                chk("a_done_delay", cyc - last_drive, DONE_DLY);
            end
        end
        if (!reset && bus_b.burst_done) begin
            if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_count", bus_b.pulse_count, e.cnt);
                chk("b_ok", bus_b.burst_ok, e.ok);
                chk("b_overflow", bus_b.overflow, e.ovf);
                chk("b_done_delay", cyc - last_drive, DONE_DLY);
            end
        end
    end

    initial begin
        exp_t eb;
        bus_a.trig_in = 3'b000; bus_a.clear = 1'b0;
        bus_b.trig_in = 3'b000; bus_b.clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_done", bus_a.burst_done, 0);
        chk("rst_count", bus_a.pulse_count, 0);
        chk("rst_ok", bus_a.burst_ok, 0);
        chk("rst_lane_err", bus_a.lane_err, 0);
        chk("rst_overflow", bus_a.overflow, 0);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("static_no_event", bus_a.busy, 0);

        push_a(200, 1, 0, 0);
        burst(0, 200, 0);
        wait_results();

        push_a(199, 0, 0, 0);
        burst(0, 199, 0);
        wait_results();

        push_a(200, 0, 1, 0);
        burst(0, 200, 1);
        wait_results();

        push_a(200, 1, 0, 0);
        burst(0, 200, 2);
        wait_results();

        eb.cnt = 15; eb.ok = 0; eb.lerr = 0; eb.ovf = 1;
        qb.push_back(eb);
        burst(1, 20, 0);
        wait_results();

        // Abort a burst with reset; pins are returned low so no event follows.
        burst(0, 50, 0);
        chk("mid_busy", bus_a.busy, 1);
        chk("mid_count", bus_a.pulse_count, 50);
        reset = 1'b1;
        bus_a.trig_in = 3'b000;
        @(posedge clk); #1;
        chk("abort_busy", bus_a.busy, 0);
        chk("abort_count", bus_a.pulse_count, 0);
        chk("abort_ok", bus_a.burst_ok, 0);
        chk("abort_lane_err", bus_a.lane_err, 0);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("post_abort_idle", bus_a.busy, 0);

        push_a(200, 1, 0, 0);
        burst(0, 200, 0);
        wait_results();

        bus_a.clear = 1'b1;
        @(posedge clk); #1;
        bus_a.clear = 1'b0;
        chk("clear_ok", bus_a.burst_ok, 0);
        chk("clear_count_held", bus_a.pulse_count, 200);
        chk("clear_busy", bus_a.busy, 0);

        push_a(5, 0, 0, 0);
        burst(0, 5, 0);
        wait_results();

        // Toggle timed so its event reaches the FSM in the same cycle as clear.
        push_a(1, 0, 0, 0);
        @(posedge clk); #1;
        bus_a.trig_in = ~bus_a.trig_in;
        last_drive = cyc;
        repeat (2) @(posedge clk);
        #1;
        bus_a.clear = 1'b1;
        @(posedge clk); #1;
        bus_a.clear = 1'b0;
        chk("clr_evt_busy", bus_a.busy, 1);
        chk("clr_evt_count", bus_a.pulse_count, 1);
        wait_results();

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/trigger_monitor.md
Name: trigger_monitor

Overview:
- Receive end of the trigger link: samples the 3-bit trigger toggle bus driven by the trigger generator and counts toggles per burst.
- Detects burst end by inactivity timeout, then reports count, pass/fail against the expected count, and lane-mismatch errors.
- Sits on the bench/capture board, running on the system clock; count feeds the existing BCD/7-seg display path.

Parameters:
- CNT_W, 10, width of toggle counter (max 1023)
- EXPECTED, 200, toggles per valid burst
- TIMEOUT, 5_000_000, idle clk cycles that end a burst (100 ms at 50 MHz)
- TO_W, 23, width of idle-timeout counter; must hold TIMEOUT

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- trig_in  input  3  asynchronous trigger bus; all lanes nominally identical
- clear  input  1  sync pulse; drop DONE result, return to IDLE
- busy  output  1  high while in ACTIVE
- burst_done  output  1  one-cycle pulse on ACTIVE->DONE
- pulse_count  output  CNT_W  toggles in current/last burst
- burst_ok  output  1  valid in DONE: count==EXPECTED and no errors
- lane_err  output  1  sticky per burst: lanes disagreed after settling
- overflow  output  1  sticky per burst: count saturated

Behaviour:
- Clock: one clock, clk. Reset: reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: busy=0, burst_done=0, pulse_count=0, burst_ok=0, lane_err=0, overflow=0, state=IDLE, sync regs=0.
- Input path: each trig_in lane uses a 2-FF synchronizer, then a 1-cycle history reg. Toggle event = lane0 sync != lane0 history. Latency is 3 clk from pin to event.
- Lane check: lanes sync'd differing for 2 consecutive cycles sets lane_err. Single-cycle skew is tolerated.
- States:
  - IDLE: on toggle event -> ACTIVE. Load pulse_count=1, clear idle counter, lane_err, overflow, burst_ok.
  - ACTIVE: each toggle event increments pulse_count and clears idle counter. Otherwise idle counter increments. When idle counter reaches TIMEOUT-1 -> DONE, with burst_done=1 for that cycle. burst_ok=(pulse_count==EXPECTED)&&!lane_err&&!overflow, registered at transition.
  - DONE: hold outputs. A toggle event starts a new burst (as IDLE). clear -> IDLE with outputs held except burst_ok=0.
- Saturation: at pulse_count==2^CNT_W-1, further events set overflow and the count holds.
- Simultaneous events: clear and toggle event in the same cycle in DONE -> toggle wins (new burst). clear in ACTIVE is ignored. reset wins over everything.
- Reset mid-burst returns to IDLE with all outputs zero. Lines held static after reset produce no event, because sync/history regs reset to 0.
- burst_done never asserts in consecutive cycles.

Decomposition:
- Package trigger_pkg: state encoding (IDLE, ACTIVE, DONE) and shared constant for the default expected toggle count (200). The generator side uses the same constant.
- Sub-module trig_sync: 3-lane 2-FF synchronizer plus history reg. Outputs the sync'd bus, event, and lane_diff. Everything else lives in trigger_monitor.

Test Plan:
- Use TIMEOUT=16. After reset, drive 200 toggles on all lanes, 8 clk apart, then idle -> burst_done pulse 16 clk after the last event's detection, pulse_count=200, burst_ok=1, lane_err=0.
- 199 toggles then idle -> pulse_count=199, burst_ok=0, burst_done once.
- Lane 2 held inverted for 5 clk mid-burst, 200 toggles -> lane_err=1, burst_ok=0. A 1-clk skew on lane 1 alone -> lane_err=0.
- CNT_W=4, 20 toggles -> pulse_count=15, overflow=1, burst_ok=0.
- Assert reset at toggle 50 -> all outputs 0 next cycle, state IDLE. Next burst of 200 -> pulse_count=200, burst_ok=1.
- In DONE, pulse clear -> burst_ok=0, pulse_count held, busy=0. Then clear coincident with a toggle event -> busy=1, pulse_count=1.
